// File: rtl/piso_frame_tx.sv
// Frame transmitter: accepts NWORDS-word frames over valid/ready and emits them
// one word per cycle, with a one-frame hold buffer for gapless back-to-back frames.
module piso_frame_tx #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [WIDTH*NWORDS-1:0]   in_data_i,
  output logic                      start_o,
  output logic [WIDTH-1:0]          sdo_o,
  output logic                      sdo_valid_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int FW = WIDTH * NWORDS;
  localparam int CW = $clog2(NWORDS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   shift_q, shift_d;
  logic [FW-1:0]   hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;

  logic            xfer;
  logic            last_word;
  logic            sending;

  // in_ready depends only on the hold flag and reset, never on in_valid.
  assign in_ready_o = !hold_full_q && !rst;
  assign xfer       = in_valid_i && in_ready_o;
  assign last_word  = (cnt_q == CW'(NWORDS - 1));

  // Outputs are forced quiet while rst is high, even before the reset edge lands.
  assign sending     = (state_q == SEND) && !rst;
  assign sdo_valid_o = sending;
  assign busy_o      = sending;
  assign sdo_o       = sending ? shift_q[WIDTH-1:0] : '0;
  assign start_o     = sending && (cnt_q == '0);
  assign done_o      = done_q && !rst;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          shift_d = in_data_i;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (last_word) begin
          done_d = 1'b1;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            cnt_d       = '0;
          end else if (xfer) begin
            shift_d = in_data_i;
            cnt_d   = '0;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          shift_d = shift_q >> WIDTH;
          cnt_d   = cnt_q + CW'(1);
          // in_ready is low while hold is full, so this never overwrites a held frame.
          if (xfer) begin
            hold_d      = in_data_i;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      // NOTE: the data registers are cleared too, so a discarded frame never lingers in the datapath.
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
// Self-checking bench for piso_frame_tx: table vectors, corner sequences and
// random traffic checked against a word-queue model of the serial link.
module tb_piso_frame_tx;

  localparam int W = 16;
  localparam int N = 8;

  typedef logic [W*N-1:0] frame_t;

  typedef struct {
    logic [W-1:0] data;
    int           idx;
  } word_t;

  typedef struct {
    logic         rst;
    logic         valid;
    logic         ready_e;
    logic         valid_e;
    logic         start_e;
    logic         done_e;
    logic [W-1:0] sdo_e;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  frame_t       in_data;
  logic         start;
  logic [W-1:0] sdo;
  logic         sdo_valid;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Link model: q holds every word still owed to the link; q[0] is on the wire now.
  word_t q[$];
  logic  done_m = 1'b0;

  logic         obs_ready, obs_valid, obs_start, obs_done, obs_busy;
  logic [W-1:0] obs_sdo, prev_sdo;
  logic         last_acc;
  logic [W-1:0] cap[$];
  int           cap_first, cap_last;

  piso_frame_tx #(.WIDTH(W), .NWORDS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .start_o    (start),
    .sdo_o      (sdo),
    .sdo_valid_o(sdo_valid),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    else
      n_pass++;
  endtask

  function automatic frame_t mk_frame(input logic [W-1:0] base);
    frame_t f;
    for (int k = 0; k < N; k++) f[k*W +: W] = base + W'(k);
    return f;
  endfunction

  // One clock cycle: drive inputs, compare outputs at negedge, advance the model at posedge.
  task automatic cycle(input logic v, input frame_t d, input logic r);
    logic         m_ready, e_valid, e_start, e_done, acc;
    logic [W-1:0] e_sdo;
    rst      = r;
    in_valid = v;
    in_data  = d;
    @(negedge clk);
    m_ready = !r && (q.size() <= N);
    e_valid = !r && (q.size() > 0);
    e_sdo   = e_valid ? q[0].data : '0;
    e_start = e_valid && (q[0].idx == 0);
    e_done  = !r && done_m;
    check("in_ready",  32'(in_ready),  32'(m_ready));
    check("sdo_valid", 32'(sdo_valid), 32'(e_valid));
    check("busy",      32'(busy),      32'(e_valid));
    check("start",     32'(start),     32'(e_start));
    check("done",      32'(done),      32'(e_done));
    check("sdo",       32'(sdo),       32'(e_sdo));
    prev_sdo  = obs_sdo;
    obs_ready = in_ready;
    obs_valid = sdo_valid;
    obs_busy  = busy;
    obs_start = start;
    obs_done  = done;
    obs_sdo   = sdo;
    if (sdo_valid) begin
      if (cap.size() == 0) cap_first = cyc;
      cap_last = cyc;
      cap.push_back(sdo);
    end
    acc      = v && m_ready;
    last_acc = acc;
    @(posedge clk);
    if (r) begin
      q.delete();
      done_m = 1'b0;
    end else begin
      done_m = 1'b0;
      if (q.size() > 0) begin
        done_m = (q[0].idx == N - 1);
        void'(q.pop_front());
      end
      if (acc)
        for (int k = 0; k < N; k++) q.push_back('{data: d[k*W +: W], idx: k});
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
  endtask

  // Holds in_valid with frame f until it is accepted, bounded to 40 cycles.
  task automatic offer(input frame_t f);
    int n;
    n = 0;
    do begin
      cycle(1'b1, f, 1'b0);
      n++;
    end while (!last_acc && n < 40);
    check("offer_accepted", 32'(last_acc), 32'd1);
  endtask

  vec_t   tbl[12];
  frame_t f1;
  int     sum;
  int     low_cnt;
  logic   seen;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    obs_sdo  = '0;
    @(posedge clk);
    #1;

    // Single frame 0x0001..0x0008 offered for one cycle.
    f1 = mk_frame(16'h0001);
    tbl[0]  = '{rst: 1, valid: 0, ready_e: 0, valid_e: 0, start_e: 0, done_e: 0, sdo_e: 16'h0000};
    tbl[1]  = '{rst: 0, valid: 1, ready_e: 1, valid_e: 0, start_e: 0, done_e: 0, sdo_e: 16'h0000};
    for (int k = 0; k < N; k++)
      tbl[2+k] = '{rst: 0, valid: 0, ready_e: 1, valid_e: 1, start_e: (k == 0), done_e: 0,
                   sdo_e: W'(k + 1)};
    tbl[10] = '{rst: 0, valid: 0, ready_e: 1, valid_e: 0, start_e: 0, done_e: 1, sdo_e: 16'h0000};
    tbl[11] = '{rst: 0, valid: 0, ready_e: 1, valid_e: 0, start_e: 0, done_e: 0, sdo_e: 16'h0000};
    sum = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].valid, f1, tbl[i].rst);
      check("tbl_ready", 32'(obs_ready), 32'(tbl[i].ready_e));
      check("tbl_valid", 32'(obs_valid), 32'(tbl[i].valid_e));
      check("tbl_start", 32'(obs_start), 32'(tbl[i].start_e));
      check("tbl_done",  32'(obs_done),  32'(tbl[i].done_e));
      check("tbl_sdo",   32'(obs_sdo),   32'(tbl[i].sdo_e));
      if (obs_valid) sum += int'(obs_sdo);
    end
    check("word_sum", 32'(sum), 32'h24);

    // Back-to-back: B's start directly follows 0x1007 and coincides with A's done.
    do_reset();
    offer(mk_frame(16'h1000));
    offer(mk_frame(16'h2000));
    low_cnt = 0;
    seen    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, '0, 1'b0);
      if (!obs_ready) low_cnt++;
      if (obs_start && obs_sdo == 16'h2000) begin
        seen = 1'b1;
        check("b2b_prev_word", 32'(prev_sdo),  32'h1007);
        check("b2b_done",      32'(obs_done),  32'd1);
        check("b2b_ready",     32'(obs_ready), 32'd1);
      end
    end
    check("b2b_seen_start", 32'(seen), 32'd1);
    check("b2b_ready_low",  32'(low_cnt), 32'd7);

    // Backpressure: three frames back to back, 24 gapless words, nothing lost.
    do_reset();
    cap.delete();
    offer(mk_frame(16'h3000));
    offer(mk_frame(16'h4000));
    offer(mk_frame(16'h5000));
    check("bp_third_on_start", 32'(obs_start), 32'd1);
    check("bp_third_word",     32'(obs_sdo),   32'h4000);
    idle(20);
    check("bp_word_count", 32'(cap.size()), 32'd24);
    check("bp_no_gap",     32'(cap_last - cap_first + 1), 32'd24);
    for (int i = 0; i < 24 && i < cap.size(); i++)
      check("bp_word", 32'(cap[i]), 32'(16'h3000 + 16'h1000 * W'(i / N) + W'(i % N)));

    // Reset during word 3 with a frame buffered in hold.
    do_reset();
    offer(mk_frame(16'h6000));
    offer(mk_frame(16'h7000));
    idle(2);
    check("rst_pre_word", 32'(obs_sdo), 32'h6002);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    check("rst_valid", 32'(obs_valid), 32'd0);
    check("rst_busy",  32'(obs_busy),  32'd0);
    check("rst_ready", 32'(obs_ready), 32'd1);
    check("rst_done",  32'(obs_done),  32'd0);
    idle(3);
    offer(mk_frame(16'hAAAA));
    cycle(1'b0, '0, 1'b0);
    check("rst_new_start", 32'(obs_start), 32'd1);
    check("rst_new_word",  32'(obs_sdo),   32'hAAAA);
    idle(10);

    // Transfer presented exactly on the last-word cycle with hold empty.
    do_reset();
    offer(mk_frame(16'h8000));
    idle(7);
    cycle(1'b1, mk_frame(16'h9000), 1'b0);
    check("last_edge_word", 32'(obs_sdo),  32'h8007);
    check("last_edge_acc",  32'(last_acc), 32'd1);
    cycle(1'b0, '0, 1'b0);
    check("last_edge_start", 32'(obs_start), 32'd1);
    check("last_edge_sdo",   32'(obs_sdo),   32'h9000);
    check("last_edge_done",  32'(obs_done),  32'd1);
    idle(10);

    // in_valid held high during reset must not transfer.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, mk_frame(16'hBEEF), 1'b1);
      check("rstv_no_acc", 32'(last_acc),  32'd0);
      check("rstv_ready",  32'(obs_ready), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b0);
      check("rstv_idle", 32'(obs_valid), 32'd0);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      frame_t fr;
      logic   rv, vv;
      for (int k = 0; k < N; k++) fr[k*W +: W] = W'($urandom);
      rv = ($urandom_range(0, 63) == 0);
      vv = ($urandom_range(0, 2) != 0);
      cycle(vv, fr, rv);
    end
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/piso_frame_tx.md
# piso_frame_tx

Parallel-in, serial-out frame transmitter for the SOML decoder datapath, the sending end of the word-serial link whose receiver accumulates a frame into a parallel result. It accepts a frame of NWORDS words through a valid/ready handshake. It emits the frame one word per cycle, with a `start` pulse on the first word. A one-frame holding buffer allows gapless back-to-back frames.

## Interface
- WIDTH, 16: bits per serial word.
- NWORDS, 8: words per frame; legal range is 2..16.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  frame offered on in_data.
- in_ready  out  1  block can accept a frame; in_ready = !hold_full && !rst.
- in_data  in  WIDTH*NWORDS  frame; word k = in_data[k*WIDTH +: WIDTH]; word 0 is sent first.
- start  out  1  high only in the cycle carrying word 0.
- sdo  out  WIDTH  serial word; forced to 0 when sdo_valid is low.
- sdo_valid  out  1  sdo carries a frame word.
- busy  out  1  equal to sdo_valid (state SEND).
- done  out  1  one-cycle pulse in the cycle after a frame's last word.

## Operation
- A transfer occurs on a rising edge where in_valid && in_ready.
- Storage:
  - active shift register (WIDTH*NWORDS);
  - holding register (WIDTH*NWORDS) with a hold_full flag;
  - word counter cnt, width $clog2(NWORDS);
  - state register.
- FSM IDLE:
  - outputs: sdo = 0, sdo_valid = 0, start = 0.
  - On a transfer: in_data loads the shift register, cnt <= 0, next state SEND.
- FSM SEND:
  - outputs: sdo = shift[WIDTH-1:0], sdo_valid = 1, start = (cnt == 0).
  - Each edge: the shift register shifts right by WIDTH and cnt increments.
- Last word (state SEND, cnt == NWORDS-1). At the ending edge, the first matching case applies:
  - hold_full: the hold register loads the shift register, hold_full <= 0, cnt <= 0, state stays SEND. The next frame follows with no gap.
  - Else a transfer on this edge: in_data loads the shift register directly, cnt <= 0, state stays SEND. No gap.
  - Else: state <= IDLE.
- A transfer during SEND that is not on the last-word edge loads the hold register and sets hold_full <= 1.
- Simultaneous hold-to-shift move and new transfer cannot occur, because in_ready is low while hold_full is set.
- done is registered. It is set at the edge ending each last-word cycle and cleared at the next edge. For back-to-back frames, done is high in the same cycle as the next frame's start.
- Reset (any cycle, including mid-frame):
  - state IDLE, cnt 0, hold_full 0, shift and hold registers 0, done 0.
  - The in-flight frame and the buffered frame are discarded with no done pulse.
  - in_valid is ignored while rst is high.
- Output values during rst and the first cycle after: start 0, sdo 0, sdo_valid 0, busy 0, done 0. in_ready is 0 while rst is high and 1 in the first cycle after.
- No arithmetic is performed; words pass bit-exact.

## Timing
- Transfer at edge T with the block IDLE:
  - start = 1 and word 0 appear in cycle T+1 (edge T to edge T+1);
  - word k appears in cycle T+1+k;
  - done is high in cycle T+1+NWORDS.
- Frame occupancy on the link is exactly NWORDS cycles with sdo_valid continuously high.
- Throughput is one frame per NWORDS cycles when in_valid is held high. The upstream source sees in_ready drop for the cycles between a hold load and the hold-to-shift move.
- All outputs are decoded from registers only, with no combinational path from in_* to sdo, start or done.
- in_ready depends on hold_full and rst only, not on in_valid.

## Test plan
- Single frame: words 0x0001..0x0008 with in_valid for one cycle.
  - Required: start with 0x0001 in cycle T+1, then 0x0002..0x0008 on consecutive cycles, done in cycle T+9, then sdo = 0 and sdo_valid = 0.
  - A word-sum check over the received frame gives 0x0024.
- Back-to-back: frame A = 0x1000..0x1007 and frame B = 0x2000..0x2007 with in_valid held high.
  - Required: B's start is in the cycle immediately after 0x1007, and done is high in that same cycle.
  - in_ready is low from B's load into hold until B's start cycle.
- Backpressure: three frames offered continuously.
  - Required: the third is accepted only in the cycle B begins, there are no gaps across 24 cycles, and no frame is lost or duplicated.
- Reset mid-frame: assert rst for one cycle during word 3, with a frame buffered in hold.
  - Required: the next cycle shows sdo_valid 0, busy 0, in_ready 1, and no done pulse.
  - A new frame 0xAAAA.. then transmits correctly.
- Transfer on the last-word edge with hold empty: present frame C exactly in the cycle carrying word 7.
  - Required: C's start follows with no idle cycle.
- in_valid high during rst.
  - Required: no transfer occurs and the block stays IDLE after reset releases.
